// File: rtl/ex_muldiv_unit.sv
// Iterative RV64M multiply/divide unit: one result bit per cycle through a shared 2*XLEN shift register.
// IDLE accepts Start, CALC iterates XLEN times, DONE presents the sign-corrected result for one cycle.
module ex_muldiv_unit #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            Start,
    input  logic [2:0]      MulDivOp,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic            Flush,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] MulDivRes
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [2:0]          r_op;
    logic [XLEN-1:0]     r_a;
    logic [XLEN-1:0]     r_b;
    logic [XLEN-1:0]     r_spec_res;
    logic [XLEN-1:0]     r_res;
    logic [2*XLEN-1:0]   r_prod;
    logic                r_neg_q;
    logic                r_neg_r;
    logic                r_special;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_accept;
    logic                w_a_signed;
    logic                w_b_signed;
    logic                w_neg_a;
    logic                w_neg_b;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic                w_b_zero;
    logic                w_ovf;
    logic                w_special;
    logic [XLEN-1:0]     w_spec_res;
    logic [XLEN:0]       w_mul_sum;
    logic [2*XLEN-1:0]   w_mul_next;
    logic [XLEN:0]       w_div_diff;
    logic [2*XLEN-1:0]   w_div_next;
    logic [2*XLEN-1:0]   w_prod_neg;
    logic [2*XLEN-1:0]   w_mul_full;
    logic [XLEN-1:0]     w_quot;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_final;
    logic                w_done;

    assign w_accept   = (r_state == S_IDLE) && Start && !Flush;
    assign w_a_signed = (MulDivOp == 3'b001) || (MulDivOp == 3'b010) || (MulDivOp[2] && !MulDivOp[0]);
    assign w_b_signed = (MulDivOp == 3'b001) || (MulDivOp[2] && !MulDivOp[0]);
    assign w_neg_a    = w_a_signed && SrcA[XLEN-1];
    assign w_neg_b    = w_b_signed && SrcB[XLEN-1];
    assign w_mag_a    = w_neg_a ? -SrcA : SrcA;
    assign w_mag_b    = w_neg_b ? -SrcB : SrcB;
    assign w_b_zero   = (SrcB == '0);
    assign w_ovf      = MulDivOp[2] && !MulDivOp[0] && (SrcA == {1'b1, {(XLEN-1){1'b0}}}) && (SrcB == '1);
    assign w_special  = MulDivOp[2] && (w_b_zero || w_ovf);
    assign w_spec_res = w_b_zero ? (MulDivOp[1] ? SrcA : '1) : (MulDivOp[1] ? '0 : SrcA);

    // Multiply: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
    assign w_mul_sum  = {1'b0, r_prod[2*XLEN-1:XLEN]} + {1'b0, r_a};
    assign w_mul_next = r_prod[0] ? {w_mul_sum, r_prod[XLEN-1:1]} : {1'b0, r_prod[2*XLEN-1:1]};

    // Divide: upper half is the partial remainder, lower half shifts dividend out and quotient in.
    assign w_div_diff = r_prod[2*XLEN-1:XLEN-1] - {1'b0, r_b};
    assign w_div_next = w_div_diff[XLEN] ? {r_prod[2*XLEN-2:0], 1'b0}
                                         : {w_div_diff[XLEN-1:0], r_prod[XLEN-2:0], 1'b1};

    assign w_prod_neg = -r_prod;
    assign w_mul_full = r_neg_q ? w_prod_neg : r_prod;
    assign w_quot     = r_neg_q ? w_prod_neg[XLEN-1:0] : r_prod[XLEN-1:0];
    assign w_rem      = r_neg_r ? -r_prod[2*XLEN-1:XLEN] : r_prod[2*XLEN-1:XLEN];

    always_comb begin
        w_final = r_spec_res;
        if (!r_special) begin
            if (!r_op[2])
                w_final = (r_op[1:0] == 2'b00) ? w_mul_full[XLEN-1:0] : w_mul_full[2*XLEN-1:XLEN];
            else
                w_final = r_op[1] ? w_rem : w_quot;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_special ? S_DONE : S_CALC;
            S_CALC: begin
                if (Flush)
                    w_next = S_IDLE;
                else if (r_cnt == CNT_W'(1))
                    w_next = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
                w_done = !Flush;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_spec_res <= '0;
            r_res      <= '0;
            r_prod     <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_special  <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if (w_accept) begin
                r_op       <= MulDivOp;
                r_a        <= w_mag_a;
                r_b        <= w_mag_b;
                r_neg_q    <= w_neg_a ^ w_neg_b;
                r_neg_r    <= w_neg_a;
                r_special  <= w_special;
                r_spec_res <= w_spec_res;
                r_cnt      <= CNT_W'(XLEN);
                r_prod     <= MulDivOp[2] ? {{XLEN{1'b0}}, w_mag_a} : {{XLEN{1'b0}}, w_mag_b};
            end
            if (r_state == S_CALC && !Flush) begin
                r_cnt  <= r_cnt - CNT_W'(1);
                r_prod <= r_op[2] ? w_div_next : w_mul_next;
            end
            if (w_done)
                r_res <= w_final;
        end
    end

    // The result is visible in the Done cycle itself, then held from r_res.
    assign Busy      = (r_state != S_IDLE);
    assign Done      = w_done;
    assign MulDivRes = w_done ? w_final : r_res;

endmodule
